// File: rtl/sipo_pkg.sv
// Shared constants and output-state encoding for the SIPO receiver.
// Optional parity framing is selected by SIPO_PARITY_EN (see top level).
package sipo_pkg;

  localparam int SIPO_DATA_WIDTH = 32;
  localparam int SIPO_CNT_WIDTH  = 6;

  typedef enum logic {
    SIPO_EMPTY,
    SIPO_FULL
  } sipo_out_state_t;

endpackage

// File: rtl/sipo_output_buffer.sv
// Holding register with EMPTY/FULL valid-ready handshake, sticky overrun
// and parity-flag capture. Parity flag input is driven 0 unless SIPO_PARITY_EN.
module sipo_output_buffer
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = SIPO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_parity_err,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  overrun,
  output logic                  parity_err
);

  sipo_out_state_t       state_reg, state_next;
  logic                  capture;
  logic                  drop;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  overrun_reg;
  logic                  parity_err_reg;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      SIPO_EMPTY: begin
        if (load) begin
          capture    = 1'b1;
          state_next = SIPO_FULL;
        end
      end
      SIPO_FULL: begin
        // A word arriving while the consumer takes the old one replaces it with no bubble.
        if (load && ready) begin
          capture = 1'b1;
        end else if (load) begin
          drop = 1'b1;
        end else if (ready) begin
          state_next = SIPO_EMPTY;
        end
      end
      default: state_next = SIPO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= SIPO_EMPTY;
      data_reg       <= '0;
      overrun_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        data_reg       <= load_data;
        parity_err_reg <= load_parity_err;
      end
      if (clear) begin
        overrun_reg <= 1'b0;
      end else if (drop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign data       = data_reg;
  assign valid      = (state_reg == SIPO_FULL);
  assign overrun    = overrun_reg;
  assign parity_err = parity_err_reg;

endmodule

// File: rtl/sipo_deserializer_32_bit.sv
// Serial-in parallel-out receiver: shift register and bit counter feeding a
// valid/ready holding buffer. Define SIPO_PARITY_EN for DATA_WIDTH+1 bit frames with even parity.
module sipo_deserializer_32_bit
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = SIPO_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                      Clk_In,
  input  logic                      Reset_In,
  input  logic                      Serial_Data_In,
  input  logic                      Shift_Enable_In,
  input  logic                      Clear_In,
  output logic [DATA_WIDTH-1:0]     Parallel_Data_Out,
  output logic                      Data_Valid_Out,
  input  logic                      Data_Ready_In,
  output logic [SIPO_CNT_WIDTH-1:0] Bit_Count_Out,
  output logic                      Overrun_Out,
  output logic                      Parity_Error_Out,
  output logic [DATA_WIDTH-1:0]     SIPO_Shift_Register
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
`endif

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  accept;
  logic                  at_last;
  logic                  shift_en;
  logic                  complete;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_parity_err;

  assign accept  = Shift_Enable_In & ~Clear_In;
  assign at_last = (count_reg == LAST_CNT);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_reg[DATA_WIDTH-2:0], Serial_Data_In};
    end else begin : g_lsb_first
      assign shifted = {Serial_Data_In, shift_reg[DATA_WIDTH-1:1]};
    end
  endgenerate

`ifdef SIPO_PARITY_EN
  // The parity bit completes the frame but is never shifted into the word.
  assign shift_en        = accept & ~at_last;
  assign complete        = accept & at_last;
  assign word            = shift_reg;
  assign word_parity_err = (^shift_reg) ^ Serial_Data_In;
`else
  assign shift_en        = accept;
  assign complete        = accept & at_last;
  assign word            = shifted;
  assign word_parity_err = 1'b0;
`endif

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (Clear_In) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= at_last ? '0 : count_reg + CNT_W'(1);
      if (shift_en) begin
        shift_reg <= shifted;
      end
    end
  end

  sipo_output_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_output_buffer (
    .clk            (Clk_In),
    .rst            (Reset_In),
    .clear          (Clear_In),
    .load           (complete),
    .load_data      (word),
    .load_parity_err(word_parity_err),
    .ready          (Data_Ready_In),
    .data           (Parallel_Data_Out),
    .valid          (Data_Valid_Out),
    .overrun        (Overrun_Out),
    .parity_err     (Parity_Error_Out)
  );

  assign Bit_Count_Out       = SIPO_CNT_WIDTH'(count_reg);
  assign SIPO_Shift_Register = shift_reg;

endmodule
